// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the 7-segment digit decoders.
// Optional build macro BIN2BCD_BLANK_LZ_EN turns leading zero digits into 4'hF (blank).
//
// state   | meaning
// S_IDLE  | in_ready high, waiting for in_valid
// S_SHIFT | BIN_W add-3/shift iterations in flight, input ignored
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  overflow
);

  localparam int              BCD_W     = 4 * DIGITS;
  localparam int              CNT_W     = (BIN_W < 2) ? 1 : $clog2(BIN_W);
  localparam logic [31:0]     OVF_LIMIT = 32'(10 ** DIGITS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BIN_W-1:0]   r_shreg;
  logic [BCD_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [BCD_W-1:0]   r_out_bcd;
  logic               r_overflow;
  logic               w_accept;
  logic               w_last;
  logic [BCD_W-1:0]   w_work_adj;
  logic [BCD_W-1:0]   w_work_next;
  logic [BCD_W-1:0]   w_result;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign overflow  = r_overflow;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_ITER) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Every nibble is corrected in parallel before the shift.
  genvar g_d;
  generate
    for (g_d = 0; g_d < DIGITS; g_d++) begin : g_add3
      assign w_work_adj[4*g_d +: 4] = (r_work[4*g_d +: 4] >= 4'd5) ?
                                      (r_work[4*g_d +: 4] + 4'd3) :
                                      r_work[4*g_d +: 4];
    end
  endgenerate

  assign w_work_next = {w_work_adj[BCD_W-2:0], r_shreg[BIN_W-1]};

  always_comb begin
    w_result = w_work_next;
    if (r_ovf) begin
      w_result = '1;
    end
`ifdef BIN2BCD_BLANK_LZ_EN
    else begin
      logic seen;
      seen = 1'b0;
      // Digit 0 is never blanked so a zero value still shows "0".
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (w_work_next[4*d +: 4] != 4'd0) begin
          seen = 1'b1;
        end else if (!seen) begin
          w_result[4*d +: 4] = 4'hF;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_shreg <= in_bin;
        r_work  <= '0;
        r_cnt   <= '0;
        r_ovf   <= (32'(in_bin) >= OVF_LIMIT);
      end else if (r_state == S_SHIFT) begin
        r_shreg <= r_shreg << 1;
        r_work  <= w_work_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_out_bcd   <= w_result;
          r_overflow  <= r_ovf;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed and random values on a 14-bit/4-digit instance,
// plus a full 0..255 sweep on an 8-bit/3-digit instance, against a divide-by-10 model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid;
  logic        a_in_ready;
  logic [13:0] a_in_bin;
  logic        a_out_valid;
  logic [15:0] a_out_bcd;
  logic        a_overflow;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_bin;
  logic        b_out_valid;
  logic [11:0] b_out_bcd;
  logic        b_overflow;

  int n_chk = 0;
  int n_err = 0;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bin    (a_in_bin),
    .out_valid (a_out_valid),
    .out_bcd   (a_out_bcd),
    .overflow  (a_overflow)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_bin    (b_in_bin),
    .out_valid (b_out_valid),
    .out_bcd   (b_out_bcd),
    .overflow  (b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int digits);
    return (v >= pow10(digits));
  endfunction

  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
    logic [63:0]     r;
    longint unsigned x;
    int              top;
    r = '0;
    if (ref_ovf(v, digits)) begin
      for (int d = 0; d < digits; d++) r[4*d +: 4] = 4'hF;
      return r;
    end
    x   = v;
    top = 0;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      if ((x % 10) != 0) top = d;
      x = x / 10;
    end
`ifdef BIN2BCD_BLANK_LZ_EN
    for (int d = 1; d < digits; d++) begin
      if (d > top) r[4*d +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic run_a(input int unsigned v);
    int n;
    n = 0;
    while (!a_in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    a_in_bin   = 14'(v);
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("a_latency", 64'(n), 64'd14);
    chk("a_ready_at_valid", 64'(a_in_ready), 64'd1);
    chk("a_bcd", 64'(a_out_bcd), ref_bcd(v, 4));
    chk("a_ovf", 64'(a_overflow), 64'(ref_ovf(v, 4)));
  endtask

  initial begin
    int          acc_cyc[$];
    int          n_res;
    int          cyc;
    int          k;
    logic        rdy;
    int          n;
    int unsigned v;

    rst_n      = 1'b0;
    a_in_valid = 1'b0;
    a_in_bin   = '0;
    b_in_valid = 1'b0;
    b_in_bin   = '0;
    #3;
    chk("rst_ready", 64'(a_in_ready), 64'd1);
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_bcd", 64'(a_out_bcd), 64'd0);
    chk("rst_ovf", 64'(a_overflow), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_a(9999);
    chk("a_9999_const", 64'(a_out_bcd), 64'h9999);
    run_a(10000);
    chk("a_10000_const", 64'(a_out_bcd), 64'hFFFF);
    run_a(16383);
    chk("a_16383_ovf", 64'(a_overflow), 64'd1);
    run_a(42);
    run_a(0);
    run_a(7);
    run_a(100);
    for (int i = 0; i < 30; i++) run_a($urandom_range(0, 16383));

    // in_valid held high, values 1,2,3; junk presented while busy must be dropped
    cyc = 0; k = 0; n_res = 0;
    a_in_valid = 1'b1;
    a_in_bin   = 14'd1;
    for (int c = 0; c < 55; c++) begin
      rdy = a_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && a_in_valid) begin
        acc_cyc.push_back(cyc);
        k++;
      end
      if (a_out_valid) begin
        n_res++;
        chk("bb_ready_at_valid", 64'(a_in_ready), 64'd1);
        chk("bb_bcd", 64'(a_out_bcd), ref_bcd(longint'(n_res), 4));
      end
      if (a_in_ready) begin
        if (k < 3) a_in_bin = 14'(k + 1);
        else a_in_valid = 1'b0;
      end else begin
        a_in_bin = 14'($urandom_range(100, 9999));
      end
    end
    a_in_valid = 1'b0;
    chk("bb_accepts", 64'(acc_cyc.size()), 64'd3);
    chk("bb_results", 64'(n_res), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("bb_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd15);
      chk("bb_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd15);
    end

    // reset at iteration 7 of a conversion
    run_a(5555);
    a_in_bin   = 14'd4321;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_bcd", 64'(a_out_bcd), 64'd0);
    chk("mid_rst_ovf", 64'(a_overflow), 64'd0);
    chk("mid_rst_ready", 64'(a_in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (a_out_valid) n++;
    end
    chk("mid_rst_no_valid", 64'(n), 64'd0);
    run_a(1234);
    chk("a_1234_const", 64'(a_out_bcd), 64'h1234);

    // 8-bit / 3-digit sweep
    for (int i = 0; i < 256; i++) begin
      v = i;
      b_in_bin   = 8'(i);
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 30) begin
        @(posedge clk); #1; n++;
      end
      chk("b_latency", 64'(n), 64'd8);
      chk("b_bcd", 64'(b_out_bcd), ref_bcd(v, 3));
      chk("b_ovf", 64'(b_overflow), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
